// File: rtl/gray_lb_pkg.sv
// Shared constants, types and helpers for the grayscale line buffer.
// Optional macro GRAY_LB_BORDER_REPLICATE_EN is consumed by gray_line_buffer.
package gray_lb_pkg;

    localparam int LB_DW        = 8;
    localparam int LB_PPC       = 4;
    localparam int LB_MAX_WIDTH = 1920;

    // Minimum width of 1 keeps counters legal for tiny depths.
    function automatic int lb_clog2(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    localparam int LB_COL_W = lb_clog2(LB_MAX_WIDTH / LB_PPC);

    typedef logic [LB_DW-1:0]  pix_t;
    typedef pix_t [LB_PPC-1:0] beat_t;

endpackage

// File: rtl/gray_lb_line_ram.sv
// One line of history: simple dual-port RAM, read-first, shared address, registered read.
// old_o exposes the pre-write word so the next RAM in the chain can take it this cycle.
module gray_lb_line_ram #(
    parameter int WORD_W = 32,
    parameter int DEPTH  = 480,
    parameter int ADDR_W = 9
) (
    input  logic              clk_i,
    input  logic              en_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [WORD_W-1:0] wdata_i,
    output logic [WORD_W-1:0] old_o,
    output logic [WORD_W-1:0] rdata_o
);

    logic [WORD_W-1:0] mem [DEPTH];
    logic [WORD_W-1:0] rdata_q;

    assign old_o   = mem[addr_i];
    assign rdata_o = rdata_q;

    always_ff @(posedge clk_i) begin
        if (en_i) begin
            rdata_q      <= mem[addr_i];
            mem[addr_i]  <= wdata_i;
        end
    end

endmodule

// File: rtl/gray_line_buffer.sv
// Line buffer emitting WIN_ROWS-tall pixel columns per input beat, one-deep output slice.
// Define GRAY_LB_BORDER_REPLICATE_EN to replicate the nearest valid line instead of zero-filling.
module gray_line_buffer
    import gray_lb_pkg::*;
#(
    parameter int DATA_WIDTH = LB_DW,
    parameter int PPC        = LB_PPC,
    parameter int MAX_WIDTH  = LB_MAX_WIDTH,
    parameter int WIN_ROWS   = 3
) (
    input  logic                               aclk,
    input  logic                               areset,
    input  logic                               s_axis_gray_tvalid,
    output logic                               s_axis_gray_tready,
    input  logic [DATA_WIDTH*PPC-1:0]          s_axis_gray_tdata,
    input  logic                               s_axis_gray_tuser,
    input  logic                               s_axis_gray_tlast,
    output logic                               m_axis_win_tvalid,
    input  logic                               m_axis_win_tready,
    output logic [DATA_WIDTH*PPC*WIN_ROWS-1:0] m_axis_win_tdata,
    output logic                               m_axis_win_tuser,
    output logic                               m_axis_win_tlast
);

    localparam int BEAT_W = DATA_WIDTH * PPC;
    localparam int DEPTH  = MAX_WIDTH / PPC;
    localparam int COL_W  = lb_clog2(DEPTH);
    localparam int RV_W   = lb_clog2(WIN_ROWS);
    localparam logic [COL_W-1:0] COL_MAX = COL_W'(DEPTH - 1);
    localparam logic [RV_W-1:0]  RV_MAX  = RV_W'(WIN_ROWS - 1);

    logic              accept;
    logic [COL_W-1:0]  col_q, col_d, addr;
    logic [RV_W-1:0]   rv_q, rv_d, rv_eff;
    logic              vld_q, vld_d;
    logic              user_q, last_q;
    logic [BEAT_W-1:0] row0_q;
    logic [RV_W-1:0]   rvo_q;

    logic [BEAT_W-1:0] chain  [WIN_ROWS];
    logic [BEAT_W-1:0] ram_rd [WIN_ROWS-1];
    logic [BEAT_W-1:0] rows   [WIN_ROWS];
    logic [BEAT_W-1:0] chain_tail_unused;

    assign s_axis_gray_tready = !vld_q || m_axis_win_tready;
    assign accept             = s_axis_gray_tvalid && s_axis_gray_tready;

    // A start-of-frame beat behaves as column 0 of a frame with no history.
    assign addr   = s_axis_gray_tuser ? '0 : col_q;
    assign rv_eff = s_axis_gray_tuser ? '0 : rv_q;

    always_comb begin
        col_d = col_q;
        rv_d  = rv_q;
        if (accept) begin
            if (s_axis_gray_tlast)
                col_d = '0;
            else if (addr != COL_MAX)
                col_d = addr + 1'b1;
            else
                col_d = addr;
            rv_d = (s_axis_gray_tlast && rv_eff != RV_MAX) ? rv_eff + 1'b1 : rv_eff;
        end
        vld_d = accept ? 1'b1 : (m_axis_win_tready ? 1'b0 : vld_q);
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            col_q  <= '0;
            rv_q   <= '0;
            vld_q  <= 1'b0;
            user_q <= 1'b0;
            last_q <= 1'b0;
            row0_q <= '0;
            rvo_q  <= '0;
        end else begin
            col_q <= col_d;
            rv_q  <= rv_d;
            vld_q <= vld_d;
            if (accept) begin
                user_q <= s_axis_gray_tuser;
                last_q <= s_axis_gray_tlast;
                row0_q <= s_axis_gray_tdata;
                rvo_q  <= rv_eff;
            end
        end
    end

    // Each RAM takes the word its predecessor held at this column: a vertical shift chain.
    assign chain[0]          = s_axis_gray_tdata;
    assign chain_tail_unused = chain[WIN_ROWS-1];

    for (genvar k = 0; k < WIN_ROWS - 1; k++) begin : g_line
        gray_lb_line_ram #(
            .WORD_W (BEAT_W),
            .DEPTH  (DEPTH),
            .ADDR_W (COL_W)
        ) u_ram (
            .clk_i   (aclk),
            .en_i    (accept),
            .addr_i  (addr),
            .wdata_i (chain[k]),
            .old_o   (chain[k+1]),
            .rdata_o (ram_rd[k])
        );
    end

    always_comb begin
        rows[0] = row0_q;
        for (int r = 1; r < WIN_ROWS; r++)
            rows[r] = ram_rd[r-1];
    end

    // RAM read registers only move on accept, so the window holds steady under backpressure.
    always_comb begin
        m_axis_win_tdata = '0;
        for (int r = 0; r < WIN_ROWS; r++) begin
            if (RV_W'(r) <= rvo_q)
                m_axis_win_tdata[r*BEAT_W +: BEAT_W] = rows[r];
            else begin
`ifdef GRAY_LB_BORDER_REPLICATE_EN
                m_axis_win_tdata[r*BEAT_W +: BEAT_W] = rows[rvo_q];
`else
                m_axis_win_tdata[r*BEAT_W +: BEAT_W] = '0;
`endif
            end
        end
    end

    assign m_axis_win_tvalid = vld_q;
    assign m_axis_win_tuser  = user_q;
    assign m_axis_win_tlast  = last_q;

endmodule

// File: tb/tb_gray_line_buffer.sv
// Directed bench for gray_line_buffer (DW=8, PPC=4, MAX_WIDTH=8, WIN_ROWS=3; 2 beats/line).
// Honours GRAY_LB_BORDER_REPLICATE_EN when the design is built with it.
module tb_gray_line_buffer;

    logic        aclk;
    logic        areset;
    logic        s_tvalid;
    logic        s_tready;
    logic [31:0] s_tdata;
    logic        s_tuser;
    logic        s_tlast;
    logic        m_tvalid;
    logic        m_tready;
    logic [95:0] m_tdata;
    logic        m_tuser;
    logic        m_tlast;

    int checks = 0;
    int errors = 0;

    gray_line_buffer #(
        .DATA_WIDTH (8),
        .PPC        (4),
        .MAX_WIDTH  (8),
        .WIN_ROWS   (3)
    ) dut (
        .aclk               (aclk),
        .areset             (areset),
        .s_axis_gray_tvalid (s_tvalid),
        .s_axis_gray_tready (s_tready),
        .s_axis_gray_tdata  (s_tdata),
        .s_axis_gray_tuser  (s_tuser),
        .s_axis_gray_tlast  (s_tlast),
        .m_axis_win_tvalid  (m_tvalid),
        .m_axis_win_tready  (m_tready),
        .m_axis_win_tdata   (m_tdata),
        .m_axis_win_tuser   (m_tuser),
        .m_axis_win_tlast   (m_tlast)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // Pixel value 16*line + column, lane p of beat b is column 4*b+p.
    function automatic logic [31:0] beat(input int L, input int b);
        logic [31:0] d;
        d = '0;
        for (int p = 0; p < 4; p++)
            d[p*8 +: 8] = 8'(16 * L + 4 * b + p);
        return d;
    endfunction

    // Expected window for beat b of line L in a frame whose first line is base.
    function automatic logic [95:0] exp_win(input int base, input int L, input int b);
        int          rv;
        logic [31:0] rowv;
        logic [95:0] w;
        rv = L - base;
        if (rv > 2) rv = 2;
        w = '0;
        for (int r = 0; r < 3; r++) begin
            if (r <= rv)
                rowv = beat(L - r, b);
            else begin
`ifdef GRAY_LB_BORDER_REPLICATE_EN
                rowv = beat(L - rv, b);
`else
                rowv = '0;
`endif
            end
            w[r*32 +: 32] = rowv;
        end
        return w;
    endfunction

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_word(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [95:0] d, input logic u, input logic l);
        check_bit({tag, "_vld"}, m_tvalid, 1'b1);
        check_word({tag, "_data"}, m_tdata, d);
        check_bit({tag, "_user"}, m_tuser, u);
        check_bit({tag, "_last"}, m_tlast, l);
    endtask

    task automatic drive(input logic [31:0] d, input logic u, input logic l);
        s_tvalid = 1'b1;
        s_tdata  = d;
        s_tuser  = u;
        s_tlast  = l;
        @(posedge aclk);
        #1;
    endtask

    task automatic idle();
        s_tvalid = 1'b0;
        s_tuser  = 1'b0;
        s_tlast  = 1'b0;
        @(posedge aclk);
        #1;
    endtask

    initial begin
        areset   = 1'b0;
        s_tvalid = 1'b0;
        s_tdata  = '0;
        s_tuser  = 1'b0;
        s_tlast  = 1'b0;
        m_tready = 1'b1;
        #2 areset = 1'b1;
        @(posedge aclk);
        @(posedge aclk);
        #1;
        check_bit("rst_vld", m_tvalid, 1'b0);
        check_bit("rst_user", m_tuser, 1'b0);
        check_bit("rst_last", m_tlast, 1'b0);
        check_word("rst_data", m_tdata, 96'd0);
        check_bit("rst_sready", s_tready, 1'b1);
        areset = 1'b0;
        idle();
        check_bit("idle_vld", m_tvalid, 1'b0);

        // Test 1: four-line frame, free-flowing output.
        for (int L = 0; L < 4; L++) begin
            for (int b = 0; b < 2; b++) begin
                drive(beat(L, b), (L == 0 && b == 0), (b == 1));
                check_out($sformatf("t1_L%0d_b%0d", L, b), exp_win(0, L, b), (L == 0 && b == 0), (b == 1));
            end
        end
        idle();
        check_bit("t1_drain_vld", m_tvalid, 1'b0);

        // Test 2: backpressure for three clocks mid-line (frame starts at line 4).
        drive(beat(4, 0), 1'b1, 1'b0);
        check_out("t2_first", exp_win(4, 4, 0), 1'b1, 1'b0);
        m_tready = 1'b0;
        s_tvalid = 1'b1;
        s_tdata  = beat(4, 1);
        s_tuser  = 1'b0;
        s_tlast  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge aclk);
            #1;
            check_bit($sformatf("t2_hold%0d_sready", i), s_tready, 1'b0);
            check_out($sformatf("t2_hold%0d", i), exp_win(4, 4, 0), 1'b1, 1'b0);
        end
        m_tready = 1'b1;
        #1;
        check_bit("t2_release_sready", s_tready, 1'b1);
        @(posedge aclk);
        #1;
        check_out("t2_second", exp_win(4, 4, 1), 1'b0, 1'b1);
        drive(beat(5, 0), 1'b0, 1'b0);
        check_out("t2_L5_b0", exp_win(4, 5, 0), 1'b0, 1'b0);
        drive(beat(5, 1), 1'b0, 1'b1);
        check_out("t2_L5_b1", exp_win(4, 5, 1), 1'b0, 1'b1);

        // Test 3: new frame after two lines; stale RAM contents must be masked.
        for (int L = 6; L < 8; L++) begin
            for (int b = 0; b < 2; b++) begin
                drive(beat(L, b), (L == 6 && b == 0), (b == 1));
                check_out($sformatf("t3_L%0d_b%0d", L, b), exp_win(6, L, b), (L == 6 && b == 0), (b == 1));
            end
        end

        // Test 4: single-beat lines.
        drive(beat(8, 0), 1'b1, 1'b1);
        check_out("t4_x", exp_win(8, 8, 0), 1'b1, 1'b1);
        drive(beat(9, 0), 1'b0, 1'b1);
        check_out("t4_y", exp_win(8, 9, 0), 1'b0, 1'b1);
        drive(beat(10, 0), 1'b0, 1'b1);
        check_out("t4_z", exp_win(8, 10, 0), 1'b0, 1'b1);

        // Test 5: asynchronous reset while an output beat is pending.
        drive(beat(11, 0), 1'b1, 1'b0);
        check_bit("t5_pre_vld", m_tvalid, 1'b1);
        s_tvalid = 1'b0;
        s_tuser  = 1'b0;
        s_tlast  = 1'b0;
        #3 areset = 1'b1;
        #1;
        check_bit("t5_async_vld", m_tvalid, 1'b0);
        check_bit("t5_async_user", m_tuser, 1'b0);
        check_word("t5_async_data", m_tdata, 96'd0);
        @(posedge aclk);
        @(posedge aclk);
        #1;
        areset = 1'b0;
        idle();
        check_bit("t5_post_vld", m_tvalid, 1'b0);
        for (int L = 12; L < 14; L++) begin
            for (int b = 0; b < 2; b++) begin
                drive(beat(L, b), (L == 12 && b == 0), (b == 1));
                check_out($sformatf("t5_L%0d_b%0d", L, b), exp_win(12, L, b), (L == 12 && b == 0), (b == 1));
            end
        end
        idle();
        check_bit("t5_drain_vld", m_tvalid, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
